// File: rtl/memo_board_ctrl.sv
// Card-board controller for the memory-match game: 4x4 layout, grid cursor, pick strobes
// to the turn manager, pair resolution with a timed reveal of missed pairs, player toggle.
module memo_board_ctrl #(
  parameter logic [63:0] LAYOUT      = 64'h3062_5147_7415_2603,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned NPAIRS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic        sel_o,
  output logic [3:0]  card_val_o,
  output logic        card_free_o,
  output logic        player_o,
  output logic [3:0]  cursor_o,
  output logic [15:0] revealed_o,
  output logic [15:0] matched_o,
  output logic [3:0]  pairs_o,
  output logic        busy_o,
  output logic        game_over_o
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0] NPAIRS_L = 4'(NPAIRS);

  typedef enum logic [2:0] {PICK1, PICK2, CHECK, SHOW, DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     row_q, row_d;
  logic [1:0]     col_q, col_d;
  logic [3:0]     first_q, first_d;
  logic [3:0]     second_q, second_d;
  logic [CW-1:0]  holdCnt_q, holdCnt_d;
  logic [15:0]    revealed_q, revealed_d;
  logic [15:0]    matched_q, matched_d;
  logic [3:0]     pairs_q, pairs_d;
  logic           player_q, player_d;
  logic           sel_q, sel_d;
  logic [3:0]     cardVal_q, cardVal_d;
  logic           cardFree_q, cardFree_d;
  logic           busy_q, busy_d;
  logic           gameOver_q, gameOver_d;

  logic [3:0]     cursorIdx;
  logic           pickFree;
  logic [3:0]     pairsInc;

  function automatic logic [3:0] cardValue(input logic [3:0] idx);
    return LAYOUT[{idx, 2'b00} +: 4];
  endfunction

  assign cursorIdx = {row_q, col_q};
  assign pickFree  = ~(revealed_q[cursorIdx] | matched_q[cursorIdx]);
  assign pairsInc  = pairs_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    first_d    = first_q;
    second_d   = second_q;
    holdCnt_d  = holdCnt_q;
    revealed_d = revealed_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    player_d   = player_q;
    sel_d      = 1'b0;
    cardVal_d  = 4'd0;
    cardFree_d = 1'b0;

    if (btn_up) begin
      row_d = row_q - 2'd1;
    end else if (btn_down) begin
      row_d = row_q + 2'd1;
    end else if (btn_left) begin
      col_d = col_q - 2'd1;
    end else if (btn_right) begin
      col_d = col_q + 2'd1;
    end

    case (state_q)
      PICK1: begin
        if (btn_sel) begin
          sel_d      = 1'b1;
          cardVal_d  = cardValue(cursorIdx);
          cardFree_d = pickFree;
          if (pickFree) begin
            revealed_d[cursorIdx] = 1'b1;
            first_d               = cursorIdx;
            state_d               = PICK2;
          end
        end
      end
      PICK2: begin
        if (btn_sel) begin
          sel_d      = 1'b1;
          cardVal_d  = cardValue(cursorIdx);
          cardFree_d = pickFree;
          if (pickFree) begin
            revealed_d[cursorIdx] = 1'b1;
            second_d              = cursorIdx;
            state_d               = CHECK;
          end
        end
      end
      CHECK: begin
        if (cardValue(first_q) == cardValue(second_q)) begin
          matched_d[first_q]   = 1'b1;
          matched_d[second_q]  = 1'b1;
          revealed_d[first_q]  = 1'b0;
          revealed_d[second_q] = 1'b0;
          pairs_d              = (pairs_q >= NPAIRS_L) ? pairs_q : pairsInc;
          state_d              = (pairsInc == NPAIRS_L) ? DONE : PICK1;
        end else begin
          holdCnt_d = HOLD_LOAD;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        // Leaving as the count reaches zero makes CHECK plus SHOW span exactly HOLD_CYCLES.
        if (holdCnt_q <= CW'(1)) begin
          holdCnt_d            = '0;
          revealed_d[first_q]  = 1'b0;
          revealed_d[second_q] = 1'b0;
          player_d             = ~player_q;
          state_d              = PICK1;
        end else begin
          holdCnt_d = holdCnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = PICK1;
      end
    endcase

    busy_d     = (state_d == CHECK) || (state_d == SHOW);
    gameOver_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PICK1;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      first_q    <= 4'd0;
      second_q   <= 4'd0;
      holdCnt_q  <= '0;
      revealed_q <= 16'd0;
      matched_q  <= 16'd0;
      pairs_q    <= 4'd0;
      player_q   <= 1'b0;
      sel_q      <= 1'b0;
      cardVal_q  <= 4'd0;
      cardFree_q <= 1'b0;
      busy_q     <= 1'b0;
      gameOver_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      first_q    <= first_d;
      second_q   <= second_d;
      holdCnt_q  <= holdCnt_d;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      pairs_q    <= pairs_d;
      player_q   <= player_d;
      sel_q      <= sel_d;
      cardVal_q  <= cardVal_d;
      cardFree_q <= cardFree_d;
      busy_q     <= busy_d;
      gameOver_q <= gameOver_d;
    end
  end

  assign sel_o       = sel_q;
  assign card_val_o  = cardVal_q;
  assign card_free_o = cardFree_q;
  assign player_o    = player_q;
  assign cursor_o    = {row_q, col_q};
  assign revealed_o  = revealed_q;
  assign matched_o   = matched_q;
  assign pairs_o     = pairs_q;
  assign busy_o      = busy_q;
  assign game_over_o = gameOver_q;

endmodule

// File: tb/tb_memo_board_ctrl.sv
// Self-checking bench for memo_board_ctrl: scenario tasks plus a pick-strobe scoreboard
// that matches every sel_o against the value/free flag queued when btn_sel was driven.
module tb_memo_board_ctrl;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0, btnSel = 1'b0;
  logic        selO, cardFreeO, playerO, busyO, gameOverO;
  logic [3:0]  cardValO, cursorO, pairsO;
  logic [15:0] revealedO, matchedO;

  logic [3:0]  cardVals [16] = '{4'd3, 4'd0, 4'd6, 4'd2, 4'd5, 4'd1, 4'd4, 4'd7,
                                 4'd7, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd0, 4'd3};
  logic [4:0]  expQ [$];
  logic [4:0]  expPick;
  logic [1:0]  mRow = 2'd0;
  logic [1:0]  mCol = 2'd0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  memo_board_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .btn_sel(btnSel),
    .sel_o(selO), .card_val_o(cardValO), .card_free_o(cardFreeO), .player_o(playerO),
    .cursor_o(cursorO), .revealed_o(revealedO), .matched_o(matchedO), .pairs_o(pairsO),
    .busy_o(busyO), .game_over_o(gameOverO)
  );

  // Scoreboard side: every pick strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && selO) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL sel_unexpected: got sel_o=1 val=%0d free=%0b, expected no strobe",
                 cardValO, cardFreeO);
      end else begin
        expPick = expQ.pop_front();
        if ({cardValO, cardFreeO} !== expPick) begin
          mismatched++;
          $display("[TB] FAIL pick_fields: got val=%0d free=%0b, expected val=%0d free=%0b",
                   cardValO, cardFreeO, expPick[4:1], expPick[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic s);
    btnUp = u; btnDown = d; btnLeft = l; btnRight = r; btnSel = s;
    @(posedge clk); #1;
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnSel = 0;
    if (u) mRow = mRow - 2'd1;
    else if (d) mRow = mRow + 2'd1;
    else if (l) mCol = mCol - 2'd1;
    else if (r) mCol = mCol + 2'd1;
  endtask

  task automatic pick(input logic expFree, input logic withRight);
    expQ.push_back({cardVals[{mRow, mCol}], expFree});
    press(1'b0, 1'b0, 1'b0, withRight, 1'b1);
  endtask

  task automatic moveTo(input logic [3:0] idx);
    while (mRow != idx[3:2]) press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (mCol != idx[1:0]) press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (cursorO !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_cursor: got %0d, expected 0", cursorO); end
    compared++; if (revealedO !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_revealed: got %h, expected 0000", revealedO); end
    compared++; if (matchedO !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_matched: got %h, expected 0000", matchedO); end
    compared++; if (playerO !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_player: got %b, expected 0", playerO); end
    compared++; if (selO !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sel: got %b, expected 0", selO); end
    compared++; if ({gameOverO, busyO, pairsO} !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_status: got %b, expected 000000", {gameOverO, busyO, pairsO}); end
    rst = 1'b1;
    mRow = 2'd0; mCol = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_cursor_wrap();
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (cursorO !== 4'd3) begin mismatched++; $display("[TB] FAIL wrap_left: got %0d, expected 3", cursorO); end
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++; if (cursorO !== 4'd15) begin mismatched++; $display("[TB] FAIL wrap_up: got %0d, expected 15", cursorO); end
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++; if (cursorO !== 4'd3) begin mismatched++; $display("[TB] FAIL wrap_down: got %0d, expected 3", cursorO); end
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (cursorO !== 4'd0) begin mismatched++; $display("[TB] FAIL wrap_right: got %0d, expected 0", cursorO); end
    press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (cursorO !== 4'd12) begin mismatched++; $display("[TB] FAIL prio_up_right: got %0d, expected 12", cursorO); end
    press(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    compared++; if (cursorO !== 4'd0) begin mismatched++; $display("[TB] FAIL prio_down_lr: got %0d, expected 0", cursorO); end
  endtask

  task automatic test_match();
    pick(1'b1, 1'b0);
    compared++; if ({busyO, revealedO} !== {1'b0, 16'h0001}) begin mismatched++; $display("[TB] FAIL match_first: got busy=%b rev=%h, expected busy=0 rev=0001", busyO, revealedO); end
    moveTo(4'd15);
    pick(1'b1, 1'b0);
    compared++; if ({busyO, revealedO} !== {1'b1, 16'h8001}) begin mismatched++; $display("[TB] FAIL match_check: got busy=%b rev=%h, expected busy=1 rev=8001", busyO, revealedO); end
    @(posedge clk); #1;
    compared++; if (matchedO !== 16'h8001) begin mismatched++; $display("[TB] FAIL match_matched: got %h, expected 8001", matchedO); end
    compared++; if (revealedO !== 16'h0) begin mismatched++; $display("[TB] FAIL match_revealed: got %h, expected 0000", revealedO); end
    compared++; if ({pairsO, playerO, busyO} !== {4'd1, 1'b0, 1'b0}) begin mismatched++; $display("[TB] FAIL match_status: got pairs=%0d player=%b busy=%b, expected 1 0 0", pairsO, playerO, busyO); end
  endtask

  task automatic test_mismatch();
    moveTo(4'd1);
    pick(1'b1, 1'b0);
    moveTo(4'd2);
    pick(1'b1, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      compared++;
      if ({busyO, revealedO} !== {1'b1, 16'h0006}) begin
        mismatched++;
        $display("[TB] FAIL show_hold[%0d]: got busy=%b rev=%h, expected busy=1 rev=0006", i, busyO, revealedO);
      end
      if (i >= 2) begin
        compared++;
        if (selO !== 1'b0) begin mismatched++; $display("[TB] FAIL show_sel_ignored[%0d]: got %b, expected 0", i, selO); end
      end
      btnSel = (i == 1);
      @(posedge clk); #1;
    end
    btnSel = 1'b0;
    compared++; if ({busyO, revealedO} !== {1'b0, 16'h0000}) begin mismatched++; $display("[TB] FAIL show_end: got busy=%b rev=%h, expected busy=0 rev=0000", busyO, revealedO); end
    compared++; if (playerO !== 1'b1) begin mismatched++; $display("[TB] FAIL show_player: got %b, expected 1", playerO); end
    compared++; if (matchedO !== 16'h8001) begin mismatched++; $display("[TB] FAIL show_matched: got %h, expected 8001", matchedO); end
  endtask

  task automatic test_non_free();
    pick(1'b1, 1'b1);
    compared++; if ({cursorO, revealedO} !== {4'd3, 16'h0004}) begin mismatched++; $display("[TB] FAIL pick_with_move: got cur=%0d rev=%h, expected cur=3 rev=0004", cursorO, revealedO); end
    moveTo(4'd2);
    pick(1'b0, 1'b0);
    compared++; if ({busyO, revealedO} !== {1'b0, 16'h0004}) begin mismatched++; $display("[TB] FAIL repick_stays: got busy=%b rev=%h, expected busy=0 rev=0004", busyO, revealedO); end
    moveTo(4'd0);
    pick(1'b0, 1'b0);
    compared++; if (busyO !== 1'b0) begin mismatched++; $display("[TB] FAIL matched_pick_stays: got busy=%b, expected 0", busyO); end
    moveTo(4'd13);
    pick(1'b1, 1'b0);
    @(posedge clk); #1;
    compared++; if (matchedO !== 16'hA005) begin mismatched++; $display("[TB] FAIL nonfree_matched: got %h, expected a005", matchedO); end
    compared++; if ({pairsO, playerO} !== {4'd2, 1'b1}) begin mismatched++; $display("[TB] FAIL nonfree_status: got pairs=%0d player=%b, expected 2 1", pairsO, playerO); end
  endtask

  task automatic test_full_game();
    logic [3:0] order [6] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int k = 0; k < 6; k++) begin
      moveTo(order[k]);
      pick(1'b1, 1'b0);
      moveTo(4'd15 - order[k]);
      pick(1'b1, 1'b0);
      @(posedge clk); #1;
    end
    compared++; if ({pairsO, gameOverO} !== {4'd8, 1'b1}) begin mismatched++; $display("[TB] FAIL game_over: got pairs=%0d over=%b, expected 8 1", pairsO, gameOverO); end
    compared++; if ({matchedO, revealedO} !== {16'hFFFF, 16'h0000}) begin mismatched++; $display("[TB] FAIL game_cards: got m=%h r=%h, expected ffff 0000", matchedO, revealedO); end
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (selO !== 1'b0) begin mismatched++; $display("[TB] FAIL done_sel_ignored: got %b, expected 0", selO); end
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if ({cursorO, gameOverO} !== {mRow, mCol, 1'b1}) begin mismatched++; $display("[TB] FAIL done_cursor: got cur=%0d over=%b, expected cur=%0d over=1", cursorO, gameOverO, {mRow, mCol}); end
  endtask

  task automatic test_reset_mid_show();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mRow = 2'd0; mCol = 2'd0;
    @(posedge clk); #1;
    pick(1'b1, 1'b0);
    moveTo(4'd1);
    pick(1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++; if ({busyO, playerO, revealedO} !== {1'b1, 1'b0, 16'h0003}) begin mismatched++; $display("[TB] FAIL pre_reset_show: got busy=%b player=%b rev=%h, expected 1 0 0003", busyO, playerO, revealedO); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if ({revealedO, matchedO} !== 32'h0) begin mismatched++; $display("[TB] FAIL async_reset_cards: got r=%h m=%h, expected 0000 0000", revealedO, matchedO); end
    compared++; if ({cursorO, pairsO, busyO, playerO, selO, cardValO, cardFreeO, gameOverO} !== 17'h0) begin mismatched++; $display("[TB] FAIL async_reset_status: got %h, expected 0", {cursorO, pairsO, busyO, playerO, selO, cardValO, cardFreeO, gameOverO}); end
    compared++; if (expQ.size() !== 0) begin mismatched++; $display("[TB] FAIL pending_picks: got %0d queued, expected 0", expQ.size()); end
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_match();
    test_mismatch();
    test_non_free();
    test_full_game();
    test_reset_mid_show();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memo_board_ctrl.md
Name: memo_board_ctrl

Overview:
Card-board controller for the memory-match game and the upstream stage of the turn/score manager. It holds the 4x4 card layout and drives a grid cursor from one-cycle button pulses. On each pick it emits a select pulse with the card value and a "card free" flag to the turn manager. It also resolves pair matches, hides mismatched pairs after a display hold, and toggles the active player on a miss.

Parameters:
LAYOUT, 64'h3062_5147_7415_2603, card i value = LAYOUT[4i+3:4i]; each value 0..7 appears exactly twice
HOLD_CYCLES, 50_000_000, clock cycles a mismatched pair stays revealed (1 s at 50 MHz); must be >= 1
NPAIRS, 8, pairs needed for game over

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
btn_up  in  1  one-cycle pulse, cursor row-1
btn_down  in  1  one-cycle pulse, cursor row+1
btn_left  in  1  one-cycle pulse, cursor col-1
btn_right  in  1  one-cycle pulse, cursor col+1
btn_sel  in  1  one-cycle pulse, pick card at cursor
sel_o  out  1  one-cycle pick strobe to turn manager (its select)
card_val_o  out  4  value of picked card, valid while sel_o=1 (its state)
card_free_o  out  1  picked card was hidden and unmatched (its empty)
player_o  out  1  active player, 0=J1, 1=J2
cursor_o  out  4  cursor index = row*4+col
revealed_o  out  16  face-up, unmatched cards
matched_o  out  16  matched cards
pairs_o  out  4  pairs found so far
busy_o  out  1  high in CHECK and SHOW
game_over_o  out  1  all pairs matched

Behaviour:
- Reset (async, rst=0): all outputs 0, cursor 0 (row 0, col 0), FSM=PICK1, hold counter 0, first-pick index 0. Reset mid-SHOW or mid-CHECK clears all state immediately.
- Cursor: 2-bit row and 2-bit column; moves wrap modulo 4 within the row or column (col 3 + right -> col 0; row 0 + up -> row 3). Moves are accepted in every state. If several move pulses arrive in one cycle, only the highest-priority one applies: up > down > left > right.
- Pick: a btn_sel pulse in PICK1 or PICK2 uses the cursor value from before any same-cycle move. The next cycle has sel_o=1, card_val_o=LAYOUT value and card_free_o=(card neither revealed nor matched). These fields return to 0 one cycle later.
- btn_sel in CHECK, SHOW or DONE is ignored: no sel_o and no state change.
- FSM states:
  - PICK1: a free pick sets its revealed bit, latches the index as first, and goes to PICK2. A non-free pick pulses sel_o with free=0 and stays in PICK1.
  - PICK2: a free pick sets its revealed bit, latches the index as second, and goes to CHECK. A non-free pick, including re-picking first, pulses sel_o with free=0 and stays in PICK2.
  - CHECK (1 cycle): values equal -> set both matched bits, clear both revealed bits, pairs+1. Then go to DONE if pairs+1 == NPAIRS, otherwise PICK1. The player does not change on a match. Values unequal -> load hold counter with HOLD_CYCLES-1 and go to SHOW.
  - SHOW: decrement the counter each cycle. At 0, clear both revealed bits, toggle player_o and go to PICK1. The pair is visible for exactly HOLD_CYCLES cycles.
  - DONE: game_over_o=1; terminal until reset. Cursor moves still work.
- pairs_o saturates at NPAIRS. matched_o and revealed_o are never both set for the same card.
- All outputs are registered.

Test Plan:
- Reset then idle -> cursor_o=0, revealed_o=0, matched_o=0, player_o=0, sel_o=0, game_over_o=0.
- Cursor wrap: from cursor 0, btn_left -> 3; btn_up -> 15; btn_up and btn_right in the same cycle from 0 -> 12 (up wins).
- Match: pick card 0 -> sel_o=1 with val=3, free=1; move to card 15 and pick -> val=3, free=1. One cycle later matched_o=16'h8001, revealed_o=0, pairs_o=1, player_o=0.
- Mismatch (HOLD_CYCLES=4): pick cards 0 and 1 (values 3, 0) -> revealed_o=16'h0003 and busy_o=1 for 4 cycles. Then revealed_o=0 and player_o=1. btn_sel during SHOW gives no sel_o.
- Non-free pick: pick card 0, then pick card 0 again -> second sel_o has free=0, val=3, FSM stays in PICK2. Picking a matched card -> free=0.
- Full game: match all 8 pairs -> pairs_o=8, game_over_o=1, further btn_sel ignored. Assert rst=0 mid-SHOW -> all outputs 0 asynchronously.
